multicycle_ctrl: RTL

- Multi-cycle control FSM that drives the ALU control interface: alu_op, op_A_sel, op_B_sel and sign-extension select.
- Consumes the ALU branch flag f.
- Sequences instruction fetch, decode, execute, memory and writeback through valid/ack handshakes to instruction and data memory.
- Issues register-file write and PC-update strobes.

---
 rtl/multicycle_ctrl_pkg.sv | 74 +++++++
 rtl/ctrl_decode.sv | 112 +++++++++++
 rtl/multicycle_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle control FSM.
//   - ALU operation codes driven on alu_op
//   - RV32 opcode constants recognised by the decoder
//   - immediate-format, writeback-source and next-PC-source encodings
//   - FSM state and instruction-class enums
package multicycle_ctrl_pkg;

  // ALU operation codes
  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_SLL = 4'h2;
  localparam logic [3:0] ALU_SRL = 4'h3;
  localparam logic [3:0] ALU_SRA = 4'h4;
  localparam logic [3:0] ALU_OR  = 4'h5;
  localparam logic [3:0] ALU_XOR = 4'h6;
  localparam logic [3:0] ALU_AND = 4'h7;
  localparam logic [3:0] ALU_BEQ = 4'h8;
  localparam logic [3:0] ALU_BLT = 4'h9;
  localparam logic [3:0] ALU_BNE = 4'hA;
  localparam logic [3:0] ALU_BGE = 4'hB;

  // Opcodes (IR[6:0])
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  // funct7 values that select the base / alternate operation
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Immediate formats (sext_op)
  localparam logic [2:0] SEXT_I = 3'd0;
  localparam logic [2:0] SEXT_S = 3'd1;
  localparam logic [2:0] SEXT_B = 3'd2;
  localparam logic [2:0] SEXT_U = 3'd3;
  localparam logic [2:0] SEXT_J = 3'd4;

  // Writeback sources (wb_sel)
  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;
  localparam logic [1:0] WB_EXT = 2'd3;

  // Next-PC sources (npc_sel)
  localparam logic [1:0] NPC_PC4   = 2'd0;
  localparam logic [1:0] NPC_PCEXT = 2'd1;
  localparam logic [1:0] NPC_ALU   = 2'd2;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    CLS_ILLEGAL = 4'd0,
    CLS_ALU_R   = 4'd1,
    CLS_ALU_I   = 4'd2,
    CLS_LOAD    = 4'd3,
    CLS_STORE   = 4'd4,
    CLS_BRANCH  = 4'd5,
    CLS_JAL     = 4'd6,
    CLS_JALR    = 4'd7,
    CLS_LUI     = 4'd8
  } inst_class_t;

endpackage

// File: rtl/ctrl_decode.sv
// Purely combinational instruction decoder.
// Ports:
//   opcode     in  7  IR[6:0]
//   funct3     in  3  IR[14:12]
//   funct7     in  7  IR[31:25]
//   inst_class out    instruction class (CLS_ILLEGAL for unsupported encodings)
//   alu_op     out 4  ALU operation used in EXEC (and held through MEM/WB)
//   sext_op    out 3  immediate format for the sign-extension unit
module ctrl_decode
  import multicycle_ctrl_pkg::*;
(
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  output inst_class_t inst_class,
  output logic [3:0]  alu_op,
  output logic [2:0]  sext_op
);

  always_comb begin
    inst_class = CLS_ILLEGAL;
    alu_op     = ALU_ADD;
    sext_op    = SEXT_I;
    case (opcode)
      OP_RTYPE: begin
        if (funct7 == F7_BASE) begin
          inst_class = CLS_ALU_R;
          case (funct3)
            3'b000:  alu_op = ALU_ADD;
            3'b001:  alu_op = ALU_SLL;
            3'b100:  alu_op = ALU_XOR;
            3'b101:  alu_op = ALU_SRL;
            3'b110:  alu_op = ALU_OR;
            3'b111:  alu_op = ALU_AND;
            default: inst_class = CLS_ILLEGAL;  // slt/sltu not supported
          endcase
        end else if (funct7 == F7_ALT) begin
          case (funct3)
            3'b000: begin
              inst_class = CLS_ALU_R;
              alu_op     = ALU_SUB;
            end
            3'b101: begin
              inst_class = CLS_ALU_R;
              alu_op     = ALU_SRA;
            end
            default: inst_class = CLS_ILLEGAL;
          endcase
        end
      end
      OP_ITYPE: begin
        sext_op = SEXT_I;
        case (funct3)
          3'b000: begin inst_class = CLS_ALU_I; alu_op = ALU_ADD; end
          3'b100: begin inst_class = CLS_ALU_I; alu_op = ALU_XOR; end
          3'b110: begin inst_class = CLS_ALU_I; alu_op = ALU_OR;  end
          3'b111: begin inst_class = CLS_ALU_I; alu_op = ALU_AND; end
          3'b001: begin
            if (funct7 == F7_BASE) begin
              inst_class = CLS_ALU_I;
              alu_op     = ALU_SLL;
            end
          end
          3'b101: begin
            // Shift-immediates reuse funct7 (IR[31:25]) to pick logical vs arithmetic
            if (funct7 == F7_BASE) begin
              inst_class = CLS_ALU_I;
              alu_op     = ALU_SRL;
            end else if (funct7 == F7_ALT) begin
              inst_class = CLS_ALU_I;
              alu_op     = ALU_SRA;
            end
          end
          default: inst_class = CLS_ILLEGAL;
        endcase
      end
      OP_LOAD: begin
        sext_op = SEXT_I;
        if (funct3 == 3'b010) inst_class = CLS_LOAD;
      end
      OP_STORE: begin
        sext_op = SEXT_S;
        if (funct3 == 3'b010) inst_class = CLS_STORE;
      end
      OP_BRANCH: begin
        sext_op    = SEXT_B;
        inst_class = CLS_BRANCH;
        case (funct3)
          3'b000:  alu_op = ALU_BEQ;
          3'b001:  alu_op = ALU_BNE;
          3'b100:  alu_op = ALU_BLT;
          3'b101:  alu_op = ALU_BGE;
          default: inst_class = CLS_ILLEGAL;
        endcase
      end
      OP_JAL: begin
        sext_op    = SEXT_J;
        inst_class = CLS_JAL;
      end
      OP_JALR: begin
        sext_op = SEXT_I;
        if (funct3 == 3'b000) inst_class = CLS_JALR;
      end
      OP_LUI: begin
        sext_op    = SEXT_U;
        inst_class = CLS_LUI;
      end
      default: inst_class = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM: FETCH -> DECODE -> EXEC -> (MEM) -> (WB) -> FETCH.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   imem_req/ack    instruction fetch handshake; inst captured into IR on ack
//   inst            fetched instruction word
//   alu_op, op_A_sel, op_B_sel, sext_op   ALU / immediate control
//   f               ALU branch flag, only looked at in EXEC of a branch
//   dmem_req/we/ack data memory handshake
//   rf_we, wb_sel   register-file write strobe and writeback source
//   pc_we, npc_sel  PC update strobe and next-PC source
//   illegal_inst    one-cycle pulse in DECODE for unsupported encodings
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_IR = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [31:0] inst,
  output logic [3:0]  alu_op,
  output logic        op_A_sel,
  output logic        op_B_sel,
  output logic [2:0]  sext_op,
  input  logic        f,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        pc_we,
  output logic [1:0]  npc_sel,
  output logic        illegal_inst
);

  state_t      state_reg, state_next;
  logic [31:0] ir_reg, ir_next;

  inst_class_t dec_class;
  logic [3:0]  dec_alu_op;
  logic [2:0]  dec_sext_op;
  logic        dec_a_sel;
  logic        dec_b_sel;
  logic        rd_nonzero;

  // Register-source fields are consumed by the datapath, not by control
  logic unused_ir_bits;
  assign unused_ir_bits = ^ir_reg[24:15];

  ctrl_decode u_decode (
    .opcode     (ir_reg[6:0]),
    .funct3     (ir_reg[14:12]),
    .funct7     (ir_reg[31:25]),
    .inst_class (dec_class),
    .alu_op     (dec_alu_op),
    .sext_op    (dec_sext_op)
  );

  // Operand A is the PC only for jal (lui ignores the ALU result, so 0 is fine).
  assign dec_a_sel  = !(dec_class == CLS_JAL || dec_class == CLS_LUI);
  // Operand B is rD2 for register-register ops and branch compares.
  assign dec_b_sel  = (dec_class == CLS_ALU_R) || (dec_class == CLS_BRANCH);
  assign rd_nonzero = (ir_reg[11:7] != 5'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_FETCH;
      ir_reg    <= RESET_IR;
    end else begin
      state_reg <= state_next;
      ir_reg    <= ir_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ir_next    = ir_reg;
    case (state_reg)
      ST_FETCH: begin
        if (imem_ack) begin
          ir_next    = inst;
          state_next = ST_DECODE;
        end
      end
      ST_DECODE: begin
        state_next = (dec_class == CLS_ILLEGAL) ? ST_FETCH : ST_EXEC;
      end
      ST_EXEC: begin
        case (dec_class)
          CLS_BRANCH:          state_next = ST_FETCH;
          CLS_LOAD, CLS_STORE: state_next = ST_MEM;
          default:             state_next = ST_WB;
        endcase
      end
      ST_MEM: begin
        if (dmem_ack) state_next = (dec_class == CLS_STORE) ? ST_FETCH : ST_WB;
      end
      ST_WB:   state_next = ST_FETCH;
      default: state_next = ST_FETCH;
    endcase
  end

  // Outputs: Moore in state/IR except the branch npc_sel, which follows f in EXEC.
  // ALU controls stay at their EXEC values through MEM and WB so the address and
  // the jalr target on alu_c remain stable.
  always_comb begin
    imem_req     = 1'b0;
    alu_op       = ALU_ADD;
    op_A_sel     = 1'b0;
    op_B_sel     = 1'b0;
    sext_op      = SEXT_I;
    dmem_req     = 1'b0;
    dmem_we      = 1'b0;
    rf_we        = 1'b0;
    wb_sel       = WB_ALU;
    pc_we        = 1'b0;
    npc_sel      = NPC_PC4;
    illegal_inst = 1'b0;
    if (!rst) begin
      case (state_reg)
        ST_FETCH: imem_req = 1'b1;
        ST_DECODE: begin
          sext_op = dec_sext_op;
          if (dec_class == CLS_ILLEGAL) begin
            illegal_inst = 1'b1;
            pc_we        = 1'b1;
            npc_sel      = NPC_PC4;
          end
        end
        ST_EXEC: begin
          alu_op   = dec_alu_op;
          op_A_sel = dec_a_sel;
          op_B_sel = dec_b_sel;
          sext_op  = dec_sext_op;
          if (dec_class == CLS_BRANCH) begin
            pc_we   = 1'b1;
            npc_sel = f ? NPC_PCEXT : NPC_PC4;
          end
        end
        ST_MEM: begin
          alu_op   = dec_alu_op;
          op_A_sel = dec_a_sel;
          op_B_sel = dec_b_sel;
          sext_op  = dec_sext_op;
          dmem_req = 1'b1;
          dmem_we  = (dec_class == CLS_STORE);
          if (dmem_ack && dec_class == CLS_STORE) begin
            pc_we   = 1'b1;
            npc_sel = NPC_PC4;
          end
        end
        ST_WB: begin
          alu_op   = dec_alu_op;
          op_A_sel = dec_a_sel;
          op_B_sel = dec_b_sel;
          sext_op  = dec_sext_op;
          rf_we    = rd_nonzero;
          pc_we    = 1'b1;
          case (dec_class)
            CLS_LOAD:          wb_sel = WB_MEM;
            CLS_JAL, CLS_JALR: wb_sel = WB_PC4;
            CLS_LUI:           wb_sel = WB_EXT;
            default:           wb_sel = WB_ALU;
          endcase
          case (dec_class)
            CLS_JAL:  npc_sel = NPC_PCEXT;
            CLS_JALR: npc_sel = NPC_ALU;
            default:  npc_sel = NPC_PC4;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule
